keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Electrical model of a 4x4 matrix keypad, built to be the other end of the column-scan interface.
//  The scanner drives Cols active-low, one column at a time; this block answers on Rows exactly as the switch matrix would.
//  A key press is injected via a valid/ready request: key code plus hold time.
//  Contact bounce is added on press and on release, to a deterministic schedule.
//  Used for loopback bring-up and bench tests of the keypad scan FSM and its row synchronizer.
// PARAMETERS
//  BOUNCE_PERIOD  4   cycles between contact toggles during bounce; must be >=1
//  BOUNCE_EDGES   4   contact toggles after the initial make/break; must be even; 0 = clean contact
//  HOLD_W         24  width of the HoldCycles request field
// PORTS
//  clk         in   1       system clock (6 MHz HSOSC domain)
//  reset       in   1       synchronous, active-high reset
//  KeyValid    in   1       press request valid
//  KeyCode     in   4       key to press: row=KeyCode[3:2], col=KeyCode[1:0]
//  HoldCycles  in   HOLD_W  settled-closed duration in cycles; 0 is treated as 1
//  KeyReady    out  1       high = request can be accepted
//  Busy        out  1       high from acceptance until release completes
//  Done        out  1       one-cycle pulse when release bounce completes
//  Cols        in   4       column drive from scanner, active-low
//  Rows        out  4       row sense to scanner, active-low; idle 4'hF
// BEHAVIOUR
//  Reset values (all registered, same edge): KeyReady=0, Busy=0, Done=0, Rows=4'hF, contact=open, state=IDLE.
//  KeyReady: registered; equals (state==IDLE) one cycle later, so it rises 1 cycle after reset deasserts.
//  Accept: KeyValid&&KeyReady sampled at edge T.
//   - KeyCode and HoldCycles are latched.
//   - Busy=1 and KeyReady=0 from T+1.
//   - KeyValid outside IDLE is ignored; there is no queue.
//  Let L = (BOUNCE_EDGES+1)*BOUNCE_PERIOD.
//  FSM:
//   - IDLE -> BOUNCE_IN on accept.
//   - BOUNCE_IN (L cycles, from T+1): contact closes at T+1, toggles at T+1+k*BOUNCE_PERIOD for k=1..BOUNCE_EDGES, ends closed.
//   - HELD (max(HoldCycles,1) cycles): contact closed.
//   - BOUNCE_OUT (L cycles): contact opens on entry, toggles on the same schedule, ends open.
//   - -> IDLE: Done=1 for one cycle on the IDLE entry cycle; Busy=0 that same cycle.
//  Rows: registered, 1-cycle latency from Cols/contact.
//   - Rows[r] <= ~(contact && r==row && !Cols[col]).
//   - Any other combination, including multiple columns low at once, is decided by that expression alone.
//  Cols is sampled without synchronisation, because scanner and emulator share clk.
//  Counters: the bounce counter and hold counter saturate-free and reload on each state entry; the hold counter is HOLD_W bits.
//  Reset mid-operation: immediate return to reset values on the next edge. No Done pulse; the latched request is discarded.
//  BOUNCE_EDGES odd: illegal; behaviour is undefined. The bench checks this with an assertion.
// TESTING
//  1. Reset held 3 cycles, Cols=4'b1110.
//     -> Rows=4'hF, KeyReady=0 during reset; KeyReady=1 at first cycle after release.
//  2. P=2, E=2; press KeyCode=4'h5 (row1,col1), HoldCycles=10; Cols held 4'b1101.
//     -> Busy from T+1.
//     -> Rows[1] low/high/low in 2-cycle steps from T+2.
//     -> Rows=4'b1101 steady through HELD.
//     -> Done pulses at T+1+6+10+6.
//  3. Same press; scanner walks Cols 1110,1101,1011,0111 every cycle.
//     -> Rows[1]=0 only the cycle after Cols=1101 while closed; all other rows always 1.
//  4. KeyValid=1 with KeyCode=4'hA while Busy.
//     -> ignored; KeyReady=0, and the pending key 4'h5 completes unchanged.
//  5. Reset asserted during HELD.
//     -> next cycle Rows=4'hF, Busy=0, no Done; a new press after reset behaves as in 2.
//  6. E=0, HoldCycles=0, Cols=4'b0000, KeyCode=4'hF.
//     -> contact closed exactly 1+1 cycles (1 cycle BOUNCE_IN + 1 cycle HELD); Rows[3]=0 only during those, 1-cycle delayed.

Source files
------------

// File: rtl/keypad_emulator_if.sv
// keypad_if: press-request channel of the keypad emulator.
//   KeyValid   - request valid (master -> slave)
//   KeyCode    - key to press, row=[3:2], col=[1:0] (master -> slave)
//   HoldCycles - settled-closed duration in cycles, 0 acts as 1 (master -> slave)
//   KeyReady   - request can be accepted (slave -> master)
//   Busy       - press/release sequence in progress (slave -> master)
//   Done       - one-cycle pulse when release bounce completes (slave -> master)
interface keypad_if #(
  parameter int HOLD_W = 24
);
  logic              KeyValid;
  logic [3:0]        KeyCode;
  logic [HOLD_W-1:0] HoldCycles;
  logic              KeyReady;
  logic              Busy;
  logic              Done;

  modport master (
    output KeyValid, KeyCode, HoldCycles,
    input  KeyReady, Busy, Done
  );

  modport slave (
    input  KeyValid, KeyCode, HoldCycles,
    output KeyReady, Busy, Done
  );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: electrical model of a 4x4 active-low matrix keypad.
// A scanner drives Cols (active-low, one column at a time) and this block
// answers on Rows as the switch matrix would. A press is requested through
// the keypad_if slave port; the contact bounces on make and on break with a
// deterministic schedule.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   key    - keypad_if.slave: KeyValid/KeyCode/HoldCycles in,
//            KeyReady/Busy/Done out
//   Cols   - column drive from scanner, active-low (same clock, no sync)
//   Rows   - row sense to scanner, active-low, registered; idle 4'hF
module keypad_emulator #(
  parameter int BOUNCE_PERIOD = 4,
  parameter int BOUNCE_EDGES  = 4,
  parameter int HOLD_W        = 24
) (
  input  logic       clk,
  input  logic       reset,
  keypad_if.slave    key,
  input  logic [3:0] Cols,
  output logic [3:0] Rows
);

  localparam int TICK_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam int EDGE_W = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE_IN,
    HELD,
    BOUNCE_OUT
  } state_t;

  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [EDGE_W-1:0] edges_reg, edges_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [HOLD_W-1:0] hold_cfg_reg;
  logic [3:0]        key_reg;
  logic              contact_reg, contact_next;
  logic              ready_reg, busy_reg, done_reg, done_next;
  logic [3:0]        rows_reg;
  logic [3:0]        row_hit;
  logic              accept;
  logic              tick_last;

  assign accept    = key.KeyValid && ready_reg && (state_reg == IDLE);
  assign tick_last = (tick_reg == TICK_W'(BOUNCE_PERIOD - 1));

  // Next-state and contact schedule. Within a bounce state, each time the
  // period counter wraps either one contact toggle is spent or, when none
  // remain, the state ends; this gives (BOUNCE_EDGES+1)*BOUNCE_PERIOD cycles.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    edges_next   = edges_reg;
    hold_next    = hold_reg;
    contact_next = contact_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = BOUNCE_IN;
          contact_next = 1'b1;
          tick_next    = '0;
          edges_next   = EDGE_W'(BOUNCE_EDGES);
        end
      end
      BOUNCE_IN: begin
        if (tick_last) begin
          tick_next = '0;
          if (edges_reg == '0) begin
            state_next = HELD;
            // Hold of 0 behaves as 1: the counter runs down to zero inclusive.
            hold_next  = (hold_cfg_reg == '0) ? '0 : hold_cfg_reg - HOLD_W'(1);
          end else begin
            contact_next = ~contact_reg;
            edges_next   = edges_reg - EDGE_W'(1);
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      HELD: begin
        if (hold_reg == '0) begin
          state_next   = BOUNCE_OUT;
          contact_next = 1'b0;
          tick_next    = '0;
          edges_next   = EDGE_W'(BOUNCE_EDGES);
        end else begin
          hold_next = hold_reg - HOLD_W'(1);
        end
      end
      BOUNCE_OUT: begin
        if (tick_last) begin
          tick_next = '0;
          if (edges_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            contact_next = ~contact_reg;
            edges_next   = edges_reg - EDGE_W'(1);
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so KeyReady drops
  // on the same cycle Busy rises after an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_reg     <= '0;
      edges_reg    <= '0;
      hold_reg     <= '0;
      hold_cfg_reg <= '0;
      key_reg      <= '0;
      contact_reg  <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_reg    <= tick_next;
      edges_reg   <= edges_next;
      hold_reg    <= hold_next;
      contact_reg <= contact_next;
      ready_reg   <= (state_next == IDLE);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= done_next;
      if (accept) begin
        key_reg      <= key.KeyCode;
        hold_cfg_reg <= key.HoldCycles;
      end
    end
  end

  // Switch matrix: a row is pulled low only when the closed key sits on it
  // and the key's column is driven low. Extra low columns do not matter.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign row_hit[gi] = contact_reg && (key_reg[3:2] == 2'(gi)) && !Cols[key_reg[1:0]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_reg <= 4'hF;
    end else begin
      rows_reg <= ~row_hit;
    end
  end

  assign Rows         = rows_reg;
  assign key.KeyReady = ready_reg;
  assign key.Busy     = busy_reg;
  assign key.Done     = done_reg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator. Two instances: A (period 2, 2 edges) for the
// bouncing press scenarios and B (period 1, 0 edges) for the clean-contact
// corner. Stimulus pushes per-cycle expectations and Done cycles into queues;
// a negedge monitor pops and compares.
module tb_keypad_emulator;

  localparam int P_A = 2;
  localparam int E_A = 2;
  localparam int P_B = 1;
  localparam int E_B = 0;
  localparam int HW  = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols_a, cols_b;
  logic [3:0] rows_a, rows_b;

  keypad_if #(.HOLD_W(HW)) ifa ();
  keypad_if #(.HOLD_W(HW)) ifb ();

  keypad_emulator #(.BOUNCE_PERIOD(P_A), .BOUNCE_EDGES(E_A), .HOLD_W(HW)) u_a (
    .clk(clk), .reset(reset), .key(ifa), .Cols(cols_a), .Rows(rows_a)
  );

  keypad_emulator #(.BOUNCE_PERIOD(P_B), .BOUNCE_EDGES(E_B), .HOLD_W(HW)) u_b (
    .clk(clk), .reset(reset), .key(ifb), .Cols(cols_b), .Rows(rows_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    int         inst;
    logic [3:0] rows;
    logic       busy;
    logic       ready;
    logic       done;
    int         tid;
  } exp_t;

  exp_t exp_q[$];
  int   done_q_a[$];
  int   done_q_b[$];

  initial begin
    assert ((E_A % 2 == 0) && (E_B % 2 == 0))
      else $fatal(1, "FAIL param_check: BOUNCE_EDGES must be even");
  end

  function automatic void push(input int c, input int inst, input logic [3:0] r,
                               input logic b, input logic rd, input logic d, input int tid);
    exp_t e;
    e.cyc = c; e.inst = inst; e.rows = r; e.busy = b; e.ready = rd; e.done = d; e.tid = tid;
    exp_q.push_back(e);
  endfunction

  // Monitor: per-cycle scoreboard plus Done-pulse checker.
  exp_t       me;
  logic [3:0] m_rows;
  logic       m_busy, m_ready, m_done;
  int         m_want;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      me = exp_q.pop_front();
      if (me.inst == 0) begin
        m_rows = rows_a; m_busy = ifa.Busy; m_ready = ifa.KeyReady; m_done = ifa.Done;
      end else begin
        m_rows = rows_b; m_busy = ifb.Busy; m_ready = ifb.KeyReady; m_done = ifb.Done;
      end
      total++;
      if (me.cyc != cyc || m_rows !== me.rows || m_busy !== me.busy ||
          m_ready !== me.ready || m_done !== me.done) begin
        bad++;
        $display("FAIL test%0d_state inst=%0d cyc=%0d got rows=%b busy=%b ready=%b done=%b, want rows=%b busy=%b ready=%b done=%b (at cyc %0d)",
                 me.tid, me.inst, cyc, m_rows, m_busy, m_ready, m_done,
                 me.rows, me.busy, me.ready, me.done, me.cyc);
      end
    end
    if (ifa.Done === 1'b1) begin
      total++;
      if (done_q_a.size() == 0) begin
        bad++;
        $display("FAIL done_a unexpected pulse at cyc=%0d, want none", cyc);
      end else begin
        m_want = done_q_a.pop_front();
        if (m_want != cyc) begin
          bad++;
          $display("FAIL done_a pulse at cyc=%0d, want cyc=%0d", cyc, m_want);
        end else begin
          $display("inst A release done at cyc %0d", cyc);
        end
      end
    end
    if (ifb.Done === 1'b1) begin
      total++;
      if (done_q_b.size() == 0) begin
        bad++;
        $display("FAIL done_b unexpected pulse at cyc=%0d, want none", cyc);
      end else begin
        m_want = done_q_b.pop_front();
        if (m_want != cyc) begin
          bad++;
          $display("FAIL done_b pulse at cyc=%0d, want cyc=%0d", cyc, m_want);
        end else begin
          $display("inst B release done at cyc %0d", cyc);
        end
      end
    end
  end

  // Press key 5 (row1,col1) hold 10 on instance A. Contact profile by cycle
  // offset from T+1: bounce-in 110011, held 10x1, bounce-out 001100, idle 0.
  task automatic press_a(input bit walk, input bit inject, input bit abort, input int tid);
    logic [3:0] walk_tab [4];
    logic [0:22] prof;
    logic [3:0] r;
    int t1;
    int n_i;
    walk_tab[0] = 4'b1110; walk_tab[1] = 4'b1101;
    walk_tab[2] = 4'b1011; walk_tab[3] = 4'b0111;
    prof = 23'b11001111111111110011000;
    @(negedge clk);
    t1 = cyc + 1;
    ifa.KeyValid   = 1'b1;
    ifa.KeyCode    = 4'h5;
    ifa.HoldCycles = 24'd10;
    cols_a = walk ? walk_tab[0] : 4'b1101;
    n_i = abort ? 11 : 23;
    for (int i = 0; i <= n_i; i++) begin
      if (abort && i == 10) begin
        push(t1 + i, 0, 4'hF, 1'b0, 1'b0, 1'b0, tid);
      end else if (abort && i == 11) begin
        push(t1 + i, 0, 4'hF, 1'b0, 1'b1, 1'b0, tid);
      end else begin
        r = 4'hF;
        if (i >= 1 && prof[i-1] && (!walk || (i % 4) == 1)) r = 4'b1101;
        push(t1 + i, 0, r, (i <= 21), (i >= 22), (i == 22), tid);
      end
    end
    if (!abort) done_q_a.push_back(t1 + 22);
    $display("test%0d press key=5 hold=10 walk=%0d inject=%0d abort=%0d at cyc %0d",
             tid, walk, inject, abort, cyc);
    for (int i = 0; i <= n_i; i++) begin
      @(negedge clk);
      if (i == 0) ifa.KeyValid = 1'b0;
      if (walk) cols_a = walk_tab[(i + 1) % 4];
      if (inject && i == 5) begin
        ifa.KeyValid = 1'b1; ifa.KeyCode = 4'hA; ifa.HoldCycles = 24'd3;
      end
      if (inject && i == 10) begin
        ifa.KeyValid = 1'b0; ifa.KeyCode = 4'h5; ifa.HoldCycles = 24'd10;
      end
      if (abort && i == 9)  reset = 1'b1;
      if (abort && i == 10) reset = 1'b0;
    end
  endtask

  // Clean contact, zero hold, all columns low, key F on instance B.
  task automatic press_b(input int tid);
    int t1;
    @(negedge clk);
    t1 = cyc + 1;
    ifb.KeyValid   = 1'b1;
    ifb.KeyCode    = 4'hF;
    ifb.HoldCycles = 24'd0;
    cols_b = 4'b0000;
    for (int i = 0; i <= 5; i++) begin
      push(t1 + i, 1, (i == 1 || i == 2) ? 4'b0111 : 4'hF, (i <= 2), (i >= 3), (i == 3), tid);
    end
    done_q_b.push_back(t1 + 3);
    $display("test%0d press key=F hold=0 clean at cyc %0d", tid, cyc);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i == 0) ifb.KeyValid = 1'b0;
    end
  endtask

  initial begin
    ifa.KeyValid = 1'b0; ifa.KeyCode = 4'h0; ifa.HoldCycles = '0;
    ifb.KeyValid = 1'b0; ifb.KeyCode = 4'h0; ifb.HoldCycles = '0;
    cols_a = 4'b1110;
    cols_b = 4'b1110;
    reset  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      push(c, 0, 4'hF, 1'b0, 1'b0, 1'b0, 1);
      push(c, 1, 4'hF, 1'b0, 1'b0, 1'b0, 1);
    end
    push(4, 0, 4'hF, 1'b0, 1'b1, 1'b0, 1);
    push(4, 1, 4'hF, 1'b0, 1'b1, 1'b0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("test1 reset released at cyc %0d", cyc);

    press_a(1'b0, 1'b0, 1'b0, 2);
    press_a(1'b1, 1'b0, 1'b0, 3);
    press_a(1'b1, 1'b1, 1'b0, 4);
    press_a(1'b0, 1'b0, 1'b1, 5);
    press_a(1'b0, 1'b0, 1'b0, 5);
    press_b(6);

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_exp left=%0d want 0", exp_q.size());
    end
    total++;
    if (done_q_a.size() != 0 || done_q_b.size() != 0) begin
      bad++;
      $display("FAIL drain_done left_a=%0d left_b=%0d want 0", done_q_a.size(), done_q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
